regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Clk  input  1  system clock, all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 W_data  input  DATA_W  write data.
REQ-006 W_addr  input  ADDR_W  write address.
REQ-007 W_en  input  1  write enable; also retires the pending bit of W_addr.
REQ-008 R_addr0 / R_addr1  input  ADDR_W  read addresses, ports 0/1.
REQ-009 R_en0 / R_en1  input  1  read enables, ports 0/1.
REQ-010 R_data0 / R_data1  output  DATA_W  registered read data.
REQ-011 R_valid0 / R_valid1  output  1  R_data valid strobe, one cycle per accepted read.
REQ-012 Pend0 / Pend1  output  1  registered scoreboard pending bit of the read register.
REQ-013 Rsv_addr  input  ADDR_W  reservation address; Rsv_en  input  1  reserve strobe.
REQ-014 Clr_req  input  1  start bulk clear; Clr_busy  output  1  clear in progress.
REQ-015 RQ  output  DATA_W  contents of register 0, continuously.

Function
REQ-016 Storage SHALL be DEPTH x DATA_W registers plus DEPTH pending bits.
REQ-017 In IDLE, W_en=1 SHALL write W_data to RF[W_addr] at the edge and clear pend[W_addr].
REQ-018 In IDLE, Rsv_en=1 SHALL set pend[Rsv_addr]; Rsv_en and W_en to the same address in one cycle SHALL leave the bit set (reserve wins).
REQ-019 Reads SHALL have 1-cycle latency: R_en0=1 in cycle n gives R_data0, R_valid0=1 in cycle n+1.
REQ-020 Read data SHALL bypass: if W_en=1 and W_addr=R_addr0 in the same cycle, R_data0 SHALL be W_data (same for port 1).
REQ-021 Pend0 SHALL be pend[R_addr0] before the edge, forced 0 when a same-cycle write hits R_addr0; same-cycle reservation SHALL NOT be visible.
REQ-022 R_en low SHALL give R_valid=0 next cycle; R_data and Pend SHALL hold previous values.
REQ-023 Both read ports SHALL operate independently, including identical addresses.
REQ-024 FSM states IDLE, CLEAR; IDLE -> CLEAR on Clr_req=1 with counter=0.
REQ-025 In CLEAR each cycle SHALL zero RF[counter] and pend[counter], then increment; at counter=DEPTH-1 return to IDLE (DEPTH cycles total, counter wraps to 0).
REQ-026 Clr_busy SHALL be 1 exactly in CLEAR cycles (registered, asserted the cycle after Clr_req).
REQ-027 In CLEAR, W_en, Rsv_en, R_en0, R_en1, Clr_req SHALL be ignored; R_valid outputs SHALL be 0.
REQ-028 Clr_req coincident with W_en in IDLE SHALL perform the write, then enter CLEAR.
REQ-029 RQ SHALL reflect RF[0] from the cycle after it is written, with no read enable.

Reset
REQ-030 Reset=1 at an edge SHALL zero all registers, pend bits, R_data0/1, R_valid0/1, Pend0/1, counter, and force IDLE (Clr_busy=0, RQ=0).
REQ-031 Reset SHALL dominate all other inputs, including mid-CLEAR (abort to IDLE).

Verification
REQ-032 Write 0xBEEF to reg 5, next cycle R_en0 addr 5 -> following cycle R_data0=0xBEEF, R_valid0=1, Pend0=0.
REQ-033 Same cycle W_en addr 3 data 0x1234 and R_en1 addr 3 -> next cycle R_data1=0x1234 (bypass).
REQ-034 Rsv reg 7; read 7 -> Pend=1; write 7 + read 7 same cycle -> Pend=0; Rsv+W_en on 7 together, then read -> Pend=1.
REQ-035 Fill all 16 regs nonzero, pulse Clr_req -> Clr_busy high 16 cycles, reads ignored (R_valid=0), afterwards all reads return 0, RQ=0.
REQ-036 Reset asserted at clear cycle 6 -> next cycle Clr_busy=0, all outputs 0, state IDLE; write/read resume normally.
REQ-037 Parameter sweep DATA_W=32, ADDR_W=3: write/read all 8 regs at both ports, address 7 clear wrap-around ends in IDLE.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending (scoreboard) bit
// and a sequential bulk-clear engine that walks every entry once.
module regfile_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] W_data,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] R_addr0,
    input  logic [ADDR_W-1:0] R_addr1,
    input  logic              R_en0,
    input  logic              R_en1,
    output logic [DATA_W-1:0] R_data0,
    output logic [DATA_W-1:0] R_data1,
    output logic              R_valid0,
    output logic              R_valid1,
    output logic              Pend0,
    output logic              Pend1,
    input  logic [ADDR_W-1:0] Rsv_addr,
    input  logic              Rsv_en,
    input  logic              Clr_req,
    output logic              Clr_busy,
    output logic [DATA_W-1:0] RQ
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [ADDR_W-1:0] counter;
    logic              idle;
    logic              clear_last;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd_val0;
    logic [DATA_W-1:0] rd_val1;
    logic              rd_pend0;
    logic              rd_pend1;

    assign idle       = (state == IDLE);
    assign clear_last = (counter == ADDR_W'(DEPTH - 1));
    assign Clr_busy   = (state == CLEAR);
    assign RQ         = rf[0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Clr_req)    state_next = CLEAR;
            CLEAR:   if (clear_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // The counter is held at zero while idle so every clear starts from entry 0;
    // it wraps back to zero naturally on the last clear cycle.
    always_ff @(posedge Clk) begin
        if (Reset)     counter <= '0;
        else if (idle) counter <= '0;
        else           counter <= counter + 1'b1;
    end

    // The reservation assignment comes last so it overrides a same-cycle
    // write retiring the same entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
            pend <= '0;
        end else if (idle) begin
            if (W_en) begin
                rf[W_addr]   <= W_data;
                pend[W_addr] <= 1'b0;
            end
            if (Rsv_en) pend[Rsv_addr] <= 1'b1;
        end else begin
            rf[counter]   <= '0;
            pend[counter] <= 1'b0;
        end
    end

    // A write landing this cycle is forwarded and reads as already retired.
    assign hit0     = W_en && (W_addr == R_addr0);
    assign hit1     = W_en && (W_addr == R_addr1);
    assign rd_val0  = hit0 ? W_data : rf[R_addr0];
    assign rd_val1  = hit1 ? W_data : rf[R_addr1];
    assign rd_pend0 = !hit0 && pend[R_addr0];
    assign rd_pend1 = !hit1 && pend[R_addr1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            R_valid0 <= 1'b0;
            R_data0  <= '0;
            Pend0    <= 1'b0;
        end else begin
            R_valid0 <= idle && R_en0;
            if (idle && R_en0) begin
                R_data0 <= rd_val0;
                Pend0   <= rd_pend0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            R_valid1 <= 1'b0;
            R_data1  <= '0;
            Pend1    <= 1'b0;
        end else begin
            R_valid1 <= idle && R_en1;
            if (idle && R_en1) begin
                R_data1 <= rd_val1;
                Pend1   <= rd_pend1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table through a scoreboard queue,
// bulk-clear and reset-abort sequences, and a 32-bit/8-entry parameter instance.
module tb_regfile_scoreboard;

    typedef struct {
        logic        w_en;
        logic [3:0]  w_addr;
        logic [15:0] w_data;
        logic        r_en0;
        logic [3:0]  r_addr0;
        logic        r_en1;
        logic [3:0]  r_addr1;
        logic        rsv_en;
        logic [3:0]  rsv_addr;
        logic        clr;
        logic        e_valid0;
        logic [15:0] e_data0;
        logic        e_pend0;
        logic        e_valid1;
        logic [15:0] e_data1;
        logic        e_pend1;
        logic        e_busy;
        logic [15:0] e_rq;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic [15:0] W_data, R_data0, R_data1, RQ;
    logic [3:0]  W_addr, R_addr0, R_addr1, Rsv_addr;
    logic        W_en, R_en0, R_en1, Rsv_en, Clr_req;
    logic        R_valid0, R_valid1, Pend0, Pend1, Clr_busy;

    logic [31:0] W_data_b, R_data0_b, R_data1_b, RQ_b;
    logic [2:0]  W_addr_b, R_addr0_b, R_addr1_b, Rsv_addr_b;
    logic        W_en_b, R_en0_b, R_en1_b, Rsv_en_b, Clr_req_b;
    logic        R_valid0_b, R_valid1_b, Pend0_b, Pend1_b, Clr_busy_b;

    int tests_run = 0;
    int tests_failed = 0;
    vec_t vecs[13];
    vec_t exp_q[$];
    logic [31:0] b_q[$];
    logic [31:0] b_mem[8];

    regfile_scoreboard dut (
        .Clk(Clk), .Reset(Reset),
        .W_data(W_data), .W_addr(W_addr), .W_en(W_en),
        .R_addr0(R_addr0), .R_addr1(R_addr1), .R_en0(R_en0), .R_en1(R_en1),
        .R_data0(R_data0), .R_data1(R_data1), .R_valid0(R_valid0), .R_valid1(R_valid1),
        .Pend0(Pend0), .Pend1(Pend1), .Rsv_addr(Rsv_addr), .Rsv_en(Rsv_en),
        .Clr_req(Clr_req), .Clr_busy(Clr_busy), .RQ(RQ)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(3)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .W_data(W_data_b), .W_addr(W_addr_b), .W_en(W_en_b),
        .R_addr0(R_addr0_b), .R_addr1(R_addr1_b), .R_en0(R_en0_b), .R_en1(R_en1_b),
        .R_data0(R_data0_b), .R_data1(R_data1_b), .R_valid0(R_valid0_b), .R_valid1(R_valid1_b),
        .Pend0(Pend0_b), .Pend1(Pend1_b), .Rsv_addr(Rsv_addr_b), .Rsv_en(Rsv_en_b),
        .Clr_req(Clr_req_b), .Clr_busy(Clr_busy_b), .RQ(RQ_b)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        W_en = 0; W_addr = 0; W_data = 0; R_en0 = 0; R_addr0 = 0; R_en1 = 0; R_addr1 = 0;
        Rsv_en = 0; Rsv_addr = 0; Clr_req = 0;
        W_en_b = 0; W_addr_b = 0; W_data_b = 0; R_en0_b = 0; R_addr0_b = 0; R_en1_b = 0;
        R_addr1_b = 0; Rsv_en_b = 0; Rsv_addr_b = 0; Clr_req_b = 0;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        vec_t e;
        W_en = v.w_en; W_addr = v.w_addr; W_data = v.w_data;
        R_en0 = v.r_en0; R_addr0 = v.r_addr0; R_en1 = v.r_en1; R_addr1 = v.r_addr1;
        Rsv_en = v.rsv_en; Rsv_addr = v.rsv_addr; Clr_req = v.clr;
        exp_q.push_back(v);
        tick();
        e = exp_q.pop_front();
        checkOutput($sformatf("vec%0d valid0", idx), 32'(R_valid0), 32'(e.e_valid0));
        checkOutput($sformatf("vec%0d data0", idx), 32'(R_data0), 32'(e.e_data0));
        checkOutput($sformatf("vec%0d pend0", idx), 32'(Pend0), 32'(e.e_pend0));
        checkOutput($sformatf("vec%0d valid1", idx), 32'(R_valid1), 32'(e.e_valid1));
        checkOutput($sformatf("vec%0d data1", idx), 32'(R_data1), 32'(e.e_data1));
        checkOutput($sformatf("vec%0d pend1", idx), 32'(Pend1), 32'(e.e_pend1));
        checkOutput($sformatf("vec%0d busy", idx), 32'(Clr_busy), 32'(e.e_busy));
        checkOutput($sformatf("vec%0d rq", idx), 32'(RQ), 32'(e.e_rq));
    endtask

    task automatic writeReg(input logic [3:0] a, input logic [15:0] d);
        idleInputs();
        W_en = 1; W_addr = a; W_data = d;
        tick();
        idleInputs();
    endtask

    initial begin
        int cnt;
        logic [31:0] e0, e1;

        // Directed table: inputs for one cycle, outputs expected after that edge.
        vecs[0]  = '{1,5,'hBEEF, 0,0,0,0, 0,0,0,  0,0,0,       0,0,0,       0,0};
        vecs[1]  = '{0,0,0,      1,5,0,0, 0,0,0,  1,'hBEEF,0,  0,0,0,       0,0};
        vecs[2]  = '{1,3,'h1234, 0,0,1,3, 0,0,0,  0,'hBEEF,0,  1,'h1234,0,  0,0};
        vecs[3]  = '{0,0,0,      0,0,0,0, 1,7,0,  0,'hBEEF,0,  0,'h1234,0,  0,0};
        vecs[4]  = '{0,0,0,      1,7,1,7, 0,0,0,  1,0,1,       1,0,1,       0,0};
        vecs[5]  = '{1,7,'h00AA, 1,7,0,0, 0,0,0,  1,'h00AA,0,  0,0,1,       0,0};
        vecs[6]  = '{0,0,0,      0,0,1,7, 0,0,0,  0,'h00AA,0,  1,'h00AA,0,  0,0};
        vecs[7]  = '{1,7,'h5555, 1,7,0,0, 1,7,0,  1,'h5555,0,  0,'h00AA,0,  0,0};
        vecs[8]  = '{0,0,0,      1,7,1,7, 0,0,0,  1,'h5555,1,  1,'h5555,1,  0,0};
        vecs[9]  = '{1,0,'hA5A5, 1,0,0,0, 0,0,0,  1,'hA5A5,0,  0,'h5555,1,  0,'hA5A5};
        vecs[10] = '{0,0,0,      1,2,0,0, 1,2,0,  1,0,0,       0,'h5555,1,  0,'hA5A5};
        vecs[11] = '{0,0,0,      1,2,0,0, 0,0,0,  1,0,1,       0,'h5555,1,  0,'hA5A5};
        vecs[12] = '{0,0,0,      0,0,0,0, 0,0,0,  0,0,1,       0,'h5555,1,  0,'hA5A5};

        idleInputs();
        Reset = 1;
        tick();
        tick();
        checkOutput("reset busy", 32'(Clr_busy), 0);
        checkOutput("reset valid0", 32'(R_valid0), 0);
        checkOutput("reset rq", 32'(RQ), 0);
        checkOutput("reset rq_b", RQ_b, 0);
        Reset = 0;

        for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);
        idleInputs();

        // Bulk clear: fill and reserve everything, then clear while hammering inputs.
        for (int i = 0; i < 16; i++) writeReg(4'(i), 16'((i + 1) * 16'h1111));
        for (int i = 0; i < 16; i++) begin
            Rsv_en = 1; Rsv_addr = 4'(i);
            tick();
        end
        idleInputs();
        checkOutput("fill rq", 32'(RQ), 32'h1111);
        W_en = 1; W_addr = 0; W_data = 16'hDEAD; Clr_req = 1;
        tick();
        checkOutput("clr start busy", 32'(Clr_busy), 1);
        checkOutput("clr coincident write rq", 32'(RQ), 32'hDEAD);
        for (int k = 1; k <= 16; k++) begin
            W_en = 1; W_addr = 0; W_data = 16'hFFFF; Rsv_en = 1; Rsv_addr = 0;
            R_en0 = 1; R_addr0 = 4'(k); R_en1 = 1; R_addr1 = 0; Clr_req = 1;
            tick();
            checkOutput($sformatf("clr cycle%0d busy", k), 32'(Clr_busy), (k < 16) ? 1 : 0);
            checkOutput($sformatf("clr cycle%0d valid0", k), 32'(R_valid0), 0);
            checkOutput($sformatf("clr cycle%0d valid1", k), 32'(R_valid1), 0);
        end
        idleInputs();
        for (int i = 0; i < 16; i++) begin
            R_en0 = 1; R_addr0 = 4'(i); R_en1 = 1; R_addr1 = 4'(15 - i);
            tick();
            checkOutput($sformatf("post clr r%0d valid0", i), 32'(R_valid0), 1);
            checkOutput($sformatf("post clr r%0d data0", i), 32'(R_data0), 0);
            checkOutput($sformatf("post clr r%0d pend0", i), 32'(Pend0), 0);
            checkOutput($sformatf("post clr r%0d data1", 15 - i), 32'(R_data1), 0);
            checkOutput($sformatf("post clr r%0d pend1", 15 - i), 32'(Pend1), 0);
        end
        idleInputs();
        checkOutput("post clr rq", 32'(RQ), 0);
        checkOutput("post clr busy", 32'(Clr_busy), 0);

        // Reset at clear cycle 6 aborts the clear and wipes even untouched entries.
        writeReg(4'd15, 16'h4321);
        Rsv_en = 1; Rsv_addr = 4'd15;
        tick();
        idleInputs();
        R_en0 = 1; R_addr0 = 4'd15;
        tick();
        checkOutput("pre abort data0", 32'(R_data0), 32'h4321);
        checkOutput("pre abort pend0", 32'(Pend0), 1);
        idleInputs();
        Clr_req = 1;
        tick();
        Clr_req = 0;
        for (int k = 1; k <= 5; k++) tick();
        checkOutput("abort pre busy", 32'(Clr_busy), 1);
        Reset = 1; R_en0 = 1; W_en = 1; W_addr = 0; W_data = 16'h9999;
        tick();
        Reset = 0;
        idleInputs();
        checkOutput("abort busy", 32'(Clr_busy), 0);
        checkOutput("abort data0", 32'(R_data0), 0);
        checkOutput("abort pend0", 32'(Pend0), 0);
        checkOutput("abort valid0", 32'(R_valid0), 0);
        checkOutput("abort rq", 32'(RQ), 0);
        R_en0 = 1; R_addr0 = 4'd15;
        tick();
        checkOutput("abort r15 data0", 32'(R_data0), 0);
        checkOutput("abort r15 pend0", 32'(Pend0), 0);
        idleInputs();
        writeReg(4'd4, 16'h0077);
        R_en1 = 1; R_addr1 = 4'd4;
        tick();
        idleInputs();
        checkOutput("resume valid1", 32'(R_valid1), 1);
        checkOutput("resume data1", 32'(R_data1), 32'h0077);
        tick();
        checkOutput("resume busy", 32'(Clr_busy), 0);

        // 32-bit, 8-entry instance: fill, read both ports through the queue, clear.
        for (int i = 0; i < 8; i++) begin
            b_mem[i] = $urandom;
            W_en_b = 1; W_addr_b = 3'(i); W_data_b = b_mem[i];
            tick();
        end
        idleInputs();
        checkOutput("b rq", RQ_b, b_mem[0]);
        for (int i = 0; i < 8; i++) begin
            R_en0_b = 1; R_addr0_b = 3'(i); R_en1_b = 1; R_addr1_b = 3'(7 - i);
            b_q.push_back(b_mem[i]);
            b_q.push_back(b_mem[7 - i]);
            tick();
            e0 = b_q.pop_front();
            e1 = b_q.pop_front();
            checkOutput($sformatf("b r%0d valid0", i), 32'(R_valid0_b), 1);
            checkOutput($sformatf("b r%0d data0", i), R_data0_b, e0);
            checkOutput($sformatf("b r%0d data1", 7 - i), R_data1_b, e1);
        end
        idleInputs();
        Clr_req_b = 1;
        tick();
        Clr_req_b = 0;
        checkOutput("b clr busy", 32'(Clr_busy_b), 1);
        cnt = 0;
        while (Clr_busy_b && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("b clr cycles", 32'(cnt), 8);
        R_en0_b = 1; R_addr0_b = 3'd7; R_en1_b = 1; R_addr1_b = 3'd0;
        tick();
        idleInputs();
        checkOutput("b post clr data0", R_data0_b, 0);
        checkOutput("b post clr data1", R_data1_b, 0);
        checkOutput("b post clr rq", RQ_b, 0);
        tick();
        checkOutput("b idle busy", 32'(Clr_busy_b), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
